// File: rtl/riscv_pkg.sv
// Shared RV64 definitions used by the writeback stage.
// Holds result-select encodings, load funct3 codes and the W pipeline register layout.
// Pure declarations; no logic.
package riscv_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    RESULT_SRC_ALU  = 2'b00,
    RESULT_SRC_LOAD = 2'b01,
    RESULT_SRC_PC4  = 2'b10,
    RESULT_SRC_RSVD = 2'b11
  } resultSrcE;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LD  = 3'b011;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;
  localparam logic [2:0] LOAD_LWU = 3'b110;

  // Contents of the M/W pipeline register.
  typedef struct packed {
    logic            valid;
    logic            regWrite;
    resultSrcE       resultSrc;
    logic [2:0]      funct3;
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] readData;
    logic [4:0]      rd;
    logic [XLEN-1:0] pcPlus4;
  } wRegT;

endpackage

// File: rtl/writeback_if.sv
// M-stage to W-stage bus plus the register-file write / forwarding outputs.
// master drives the M-side fields and observes W; slave is the writeback stage.
// No flow control: the stage is steered by the separate StallW/FlushW controls.
interface writeback_if;
  import riscv_pkg::*;

  logic            ValidM;
  logic            RegWriteM;
  logic [1:0]      ResultSrcM;
  logic [2:0]      Funct3M;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] RD_Memory;
  logic [4:0]      RdM;
  logic [XLEN-1:0] PCPlus4M;

  logic [4:0]      RdW;
  logic            RegWriteW;
  logic [XLEN-1:0] ResultW;
  logic            ValidW;

  modport master (
    output ValidM, RegWriteM, ResultSrcM, Funct3M, ALUResultM, RD_Memory, RdM, PCPlus4M,
    input  RdW, RegWriteW, ResultW, ValidW
  );

  modport slave (
    input  ValidM, RegWriteM, ResultSrcM, Funct3M, ALUResultM, RD_Memory, RdM, PCPlus4M,
    output RdW, RegWriteW, ResultW, ValidW
  );
endinterface

// File: rtl/writeback_load_extend.sv
// Picks the addressed byte/half/word out of a loaded doubleword and sign/zero extends it.
// Purely combinational, zero latency.
// No backpressure; low offset bits beyond natural alignment are dropped.
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] wordSel;

  // Lane selects, little-endian, truncated to natural alignment.
  always_comb begin
    byteSel = rdata[{off, 3'b000} +: 8];
    halfSel = rdata[{off[2:1], 4'b0000} +: 16];
    wordSel = rdata[{off[2], 5'b00000} +: 32];
  end

  // Extension according to load type; 3'b111 falls through to the LD case.
  always_comb begin
    ext = rdata;
    case (funct3)
      LOAD_LB:  ext = {{56{byteSel[7]}}, byteSel};
      LOAD_LBU: ext = {56'd0, byteSel};
      LOAD_LH:  ext = {{48{halfSel[15]}}, halfSel};
      LOAD_LHU: ext = {48'd0, halfSel};
      LOAD_LW:  ext = {{32{wordSel[31]}}, wordSel};
      LOAD_LWU: ext = {32'd0, wordSel};
      default:  ext = rdata;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: M/W register, load extension, result select and retired-instruction counter.
// Latency M to W is one cycle; all outputs come from W register state only.
// StallW holds W, FlushW inserts a bubble and overrides StallW.
module writeback
  import riscv_pkg::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 StallW,
  input  logic                 FlushW,
  writeback_if.slave           bus,
  output logic [CNT_WIDTH-1:0] InstRetW
);

  wRegT            wReg;
  logic [XLEN-1:0] loadExt;

  // M/W pipeline register: reset, then flush, then stall, else capture.
  always_ff @(posedge clock) begin
    if (reset || FlushW) begin
      wReg <= '0;
    end else if (!StallW) begin
      wReg.valid     <= bus.ValidM;
      wReg.regWrite  <= bus.RegWriteM;
      wReg.resultSrc <= resultSrcE'(bus.ResultSrcM);
      wReg.funct3    <= bus.Funct3M;
      wReg.aluResult <= bus.ALUResultM;
      wReg.readData  <= bus.RD_Memory;
      wReg.rd        <= bus.RdM;
      wReg.pcPlus4   <= bus.PCPlus4M;
    end
  end

  // Count instructions leaving W; a flush does not stop the departing one being counted.
  always_ff @(posedge clock) begin
    if (reset) begin
      InstRetW <= '0;
    end else if (wReg.valid && !StallW) begin
      InstRetW <= InstRetW + 1'b1;
    end
  end

  load_extend uLoadExtend (
    .rdata  (wReg.readData),
    .off    (wReg.aluResult[2:0]),
    .funct3 (wReg.funct3),
    .ext    (loadExt)
  );

  // Register-file write value; the reserved select yields zero.
  always_comb begin
    bus.ResultW = '0;
    case (wReg.resultSrc)
      RESULT_SRC_ALU:  bus.ResultW = wReg.aluResult;
      RESULT_SRC_LOAD: bus.ResultW = loadExt;
      RESULT_SRC_PC4:  bus.ResultW = wReg.pcPlus4;
      default:         bus.ResultW = '0;
    endcase
  end

  // Write port and status; x0 is never written.
  always_comb begin
    bus.RdW       = wReg.rd;
    bus.ValidW    = wReg.valid;
    bus.RegWriteW = wReg.valid & wReg.regWrite & (wReg.rd != 5'd0);
  end

endmodule
